vx_warp_ibuffer: RTL and testbench
==================================

VX_WARP_IBUFFER -- requirements
Module: VX_warp_ibuffer

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4: number of warp queues, power of 2, >=2.
REQ-002 SHALL have parameter DEPTH, default 4: entries per warp queue, power of 2, >=2.
REQ-003 SHALL have parameter DATAW, default 64: opaque instruction payload width.
REQ-004 SHALL have port clk  in  1  clock; one clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  in  1  upstream decoded instruction valid.
REQ-007 SHALL have port in_wid  in  log2(NUM_WARPS)  destination warp of the input.
REQ-008 SHALL have port in_data  in  DATAW  input payload.
REQ-009 SHALL have port in_ready  out  1  input accepted when in_valid && in_ready.
REQ-010 SHALL have port flush_valid  in  1  clear the queue of flush_wid this cycle.
REQ-011 SHALL have port flush_wid  in  log2(NUM_WARPS)  warp to flush.
REQ-012 SHALL have port out_valid  out  1  an instruction is offered to the uop sequencer stage.
REQ-013 SHALL have port out_wid  out  log2(NUM_WARPS)  warp of the offered instruction.
REQ-014 SHALL have port out_data  out  DATAW  offered payload, the head of queue out_wid.
REQ-015 SHALL have port out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
REQ-016 SHALL have port warp_full  out  NUM_WARPS  bit w set when queue w holds DEPTH entries.
REQ-017 SHALL have port warp_empty  out  NUM_WARPS  bit w set when queue w holds 0 entries.

Function
REQ-018 SHALL keep per warp a circular FIFO of DEPTH entries, with read/write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-019 SHALL drive in_ready = !warp_full[in_wid] && !(flush_valid && flush_wid == in_wid), combinationally.
REQ-020 SHALL write in_data into queue in_wid on an input handshake; the entry is first eligible for output in the following cycle, with no same-cycle bypass.
REQ-021 SHALL accept a write to a full queue in the same cycle it is popped only if warp_full was low at the start of that cycle, i.e. no full-queue write-through.
REQ-022 SHALL select the output warp round-robin: search starts at (last_granted+1) mod NUM_WARPS and picks the first non-empty queue; last_granted resets to NUM_WARPS-1.
REQ-023 SHALL update last_granted only on an output handshake.
REQ-024 SHALL lock the selection while out_valid && !out_ready, holding out_wid/out_data stable until the handshake, except as in REQ-025.
REQ-025 SHALL, on flush of the locked warp, drop out_valid for that warp in the same cycle (combinationally masked); the lock is released and arbitration resumes next cycle.
REQ-026 SHALL pop the head of queue out_wid on an output handshake, advancing its read pointer and decrementing its count.
REQ-027 SHALL, on simultaneous push and pop of the same warp, leave the count unchanged and advance both pointers.
REQ-028 SHALL, on flush, set the pointers and count of queue flush_wid to 0 at the next edge; a flush overrides any pop of that warp in the same cycle; other warps are unaffected.
REQ-029 SHALL derive warp_full and warp_empty from the registered counts only.
REQ-030 SHALL drive out_data as '0 whenever out_valid is 0.

Reset
REQ-031 SHALL, while reset is high, set all counts and pointers to 0, last_granted to NUM_WARPS-1 and the lock to clear.
REQ-032 SHALL, while reset is high, drive out_valid=0, warp_empty=all ones, warp_full=0 and in_ready=1.
REQ-033 SHALL discard everything in flight when reset is asserted mid-operation; payload RAM contents need not be cleared.

Verification
REQ-034 SHALL cover single warp: push A,B,C to w=2 with out_ready=1 -> A, B, C out on consecutive cycles starting one cycle after A's push, out_wid=2 each time.
REQ-035 SHALL cover round-robin: preload w0={X0,X1}, w1={Y0}, w3={Z0}, out_ready=1 -> output order X0, Y0, Z0, X1.
REQ-036 SHALL cover full/backpressure: push 4 entries to w1 with out_ready=0 -> warp_full[1]=1 and in_ready=0 for in_wid=1, in_ready=1 for in_wid=0, and out_data held at the first entry.
REQ-037 SHALL cover flush under lock: w0 head held with out_ready=0, then flush w0 -> out_valid=0 that cycle, warp_empty[0]=1 next cycle, and w1 head offered after that.
REQ-038 SHALL cover push, pop and flush collisions: full w2 with simultaneous pop and push -> push refused, count 3; same-cycle push and flush on w2 -> in_ready=0, queue empty next cycle.
REQ-039 SHALL cover reset mid-stream: assert reset with 3 warps non-empty -> next cycle out_valid=0 and warp_empty all ones.

Source files
------------

// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction buffer: one circular FIFO per warp feeding a
// round-robin arbiter that locks its pick until the downstream handshake.
module vx_warp_ibuffer #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 4,
  parameter int DATAW     = 64,
  localparam int WW       = $clog2(NUM_WARPS),
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WW-1:0]        in_wid,
  input  logic [DATAW-1:0]     in_data,
  output logic                 in_ready,
  input  logic                 flush_valid,
  input  logic [WW-1:0]        flush_wid,
  output logic                 out_valid,
  output logic [WW-1:0]        out_wid,
  output logic [DATAW-1:0]     out_data,
  input  logic                 out_ready,
  output logic [NUM_WARPS-1:0] warp_full,
  output logic [NUM_WARPS-1:0] warp_empty
);

  logic [DATAW-1:0] mem_q [NUM_WARPS][DEPTH];
  logic [PW-1:0]    rd_q  [NUM_WARPS];
  logic [PW-1:0]    rd_d  [NUM_WARPS];
  logic [PW-1:0]    wr_q  [NUM_WARPS];
  logic [PW-1:0]    wr_d  [NUM_WARPS];
  logic [CW-1:0]    cnt_q [NUM_WARPS];
  logic [CW-1:0]    cnt_d [NUM_WARPS];

  logic [WW-1:0] last_q, last_d;
  logic [WW-1:0] lwid_q, lwid_d;
  logic          lock_q, lock_d;
  logic [WW-1:0] sel;
  logic          found;
  logic          push, pop;

  always_comb begin
    warp_full  = '0;
    warp_empty = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_full[w]  = !reset && (cnt_q[w] == CW'(DEPTH));
      warp_empty[w] = reset || (cnt_q[w] == '0);
    end
  end

  assign in_ready = reset
                  || (!warp_full[in_wid]
                  && !(flush_valid && flush_wid == in_wid));
  assign push = in_valid && in_ready && !reset;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    if (lock_q) begin
      sel   = lwid_q;
      found = !warp_empty[lwid_q];
    end else begin
      for (int i = 1; i <= NUM_WARPS; i++) begin
        if (!found && !warp_empty[last_q + WW'(i)]) begin
          found = 1'b1;
          sel   = last_q + WW'(i);
        end
      end
    end
  end

  // A warp being flushed must never hand out a stale head.
  assign out_valid = found && !reset
                   && !(flush_valid && flush_wid == sel);
  assign out_wid   = sel;
  assign out_data  = out_valid ? mem_q[sel][rd_q[sel]] : '0;
  assign pop       = out_valid && out_ready;

  assign lock_d = out_valid && !out_ready;
  assign lwid_d = sel;
  assign last_d = pop ? sel : last_q;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      rd_d[w]  = rd_q[w];
      wr_d[w]  = wr_q[w];
      cnt_d[w] = cnt_q[w];
      if (push && in_wid == WW'(w))
        wr_d[w] = wr_q[w] + 1'b1;
      if (pop && out_wid == WW'(w))
        rd_d[w] = rd_q[w] + 1'b1;
      unique case (1'b1)
        (push && in_wid == WW'(w)) && !(pop && out_wid == WW'(w)):
          cnt_d[w] = cnt_q[w] + 1'b1;
        !(push && in_wid == WW'(w)) && (pop && out_wid == WW'(w)):
          cnt_d[w] = cnt_q[w] - 1'b1;
        default: ;
      endcase
      if (flush_valid && flush_wid == WW'(w)) begin
        rd_d[w]  = '0;
        wr_d[w]  = '0;
        cnt_d[w] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        rd_q[w]  <= '0;
        wr_q[w]  <= '0;
        cnt_q[w] <= '0;
      end
      last_q <= WW'(NUM_WARPS - 1);
      lwid_q <= '0;
      lock_q <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        rd_q[w]  <= rd_d[w];
        wr_q[w]  <= wr_d[w];
        cnt_q[w] <= cnt_d[w];
      end
      last_q <= last_d;
      lwid_q <= lwid_d;
      lock_q <= lock_d;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[in_wid][wr_q[in_wid]] <= in_data;
  end

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Directed bench for vx_warp_ibuffer: ordering, arbitration,
// backpressure, flush, collision and reset cases.
module tb_vx_warp_ibuffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_wid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        flush_valid;
  logic [1:0]  flush_wid;
  logic        out_valid;
  logic [1:0]  out_wid;
  logic [63:0] out_data;
  logic        out_ready;
  logic [3:0]  warp_full;
  logic [3:0]  warp_empty;

  int checks = 0;
  int errors = 0;

  vx_warp_ibuffer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_wid      (in_wid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .flush_valid (flush_valid),
    .flush_wid   (flush_wid),
    .out_valid   (out_valid),
    .out_wid     (out_wid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .warp_full   (warp_full),
    .warp_empty  (warp_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] w,
                      input logic [63:0] d);
    in_valid = 1'b1;
    in_wid   = w;
    in_data  = d;
  endtask

  task automatic exp_out(input string tag,
                         input logic [1:0] w,
                         input logic [63:0] d);
    chk({tag, "_v"}, out_valid, 1'b1);
    chk({tag, "_w"}, out_wid, w);
    chk({tag, "_d"}, out_data, d);
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_wid      = '0;
    in_data     = '0;
    flush_valid = 1'b0;
    flush_wid   = '0;
    out_ready   = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_empty", warp_empty, 4'hF);
    chk("rst_full", warp_full, 4'h0);
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_od", out_data, 64'h0);
    reset = 1'b0;

    // single warp stream
    out_ready = 1'b1;
    push(2'd2, 64'hA);
    #1;
    chk("s_rdy", in_ready, 1'b1);
    chk("s_nobyp", out_valid, 1'b0);
    tick();
    in_data = 64'hB;
    #1;
    exp_out("s_a", 2'd2, 64'hA);
    tick();
    in_data = 64'hC;
    #1;
    exp_out("s_b", 2'd2, 64'hB);
    tick();
    in_valid = 1'b0;
    #1;
    exp_out("s_c", 2'd2, 64'hC);
    tick();
    #1;
    chk("s_idle", out_valid, 1'b0);
    chk("s_od0", out_data, 64'h0);
    chk("s_empty", warp_empty, 4'hF);

    // round-robin
    out_ready = 1'b0;
    push(2'd0, 64'h10);
    tick();
    push(2'd0, 64'h11);
    #1;
    exp_out("rr_lock", 2'd0, 64'h10);
    tick();
    push(2'd1, 64'h20);
    tick();
    push(2'd3, 64'h30);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    exp_out("rr_x0", 2'd0, 64'h10);
    tick();
    exp_out("rr_y0", 2'd1, 64'h20);
    tick();
    exp_out("rr_z0", 2'd3, 64'h30);
    tick();
    exp_out("rr_x1", 2'd0, 64'h11);
    tick();
    chk("rr_idle", out_valid, 1'b0);

    // full and backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(2'd1, 64'h40 + 64'(i));
      tick();
    end
    in_valid = 1'b0;
    in_wid   = 2'd1;
    #1;
    chk("bp_full", warp_full, 4'b0010);
    chk("bp_rdy1", in_ready, 1'b0);
    in_wid = 2'd0;
    #1;
    chk("bp_rdy0", in_ready, 1'b1);
    exp_out("bp_hold", 2'd1, 64'h40);
    flush_valid = 1'b1;
    flush_wid   = 2'd1;
    #1;
    chk("bp_fl_ov", out_valid, 1'b0);
    tick();
    flush_valid = 1'b0;
    #1;
    chk("bp_fl_empty", warp_empty, 4'hF);
    chk("bp_fl_full", warp_full, 4'h0);

    // flush under lock
    push(2'd0, 64'h50);
    tick();
    push(2'd1, 64'h60);
    #1;
    exp_out("fl_lock", 2'd0, 64'h50);
    tick();
    in_valid    = 1'b0;
    flush_valid = 1'b1;
    flush_wid   = 2'd0;
    #1;
    chk("fl_ov", out_valid, 1'b0);
    tick();
    flush_valid = 1'b0;
    #1;
    chk("fl_empty", warp_empty, 4'b1101);
    exp_out("fl_next", 2'd1, 64'h60);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("fl_idle", out_valid, 1'b0);

    // push/pop collision on a full queue
    for (int i = 0; i < 4; i++) begin
      push(2'd2, 64'h70 + 64'(i));
      tick();
    end
    push(2'd2, 64'h74);
    out_ready = 1'b1;
    #1;
    chk("co_full", warp_full, 4'b0100);
    chk("co_rdy", in_ready, 1'b0);
    exp_out("co_r0", 2'd2, 64'h70);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("co_full3", warp_full, 4'h0);
    chk("co_empty3", warp_empty, 4'b1011);
    exp_out("co_r1", 2'd2, 64'h71);
    out_ready = 1'b1;
    tick();
    exp_out("co_r2", 2'd2, 64'h72);
    tick();
    exp_out("co_r3", 2'd2, 64'h73);
    tick();
    chk("co_cnt3", out_valid, 1'b0);
    chk("co_drain", warp_empty, 4'hF);

    // push and flush on the same warp
    out_ready = 1'b0;
    push(2'd2, 64'h80);
    tick();
    push(2'd2, 64'h81);
    flush_valid = 1'b1;
    flush_wid   = 2'd2;
    #1;
    chk("pf_rdy", in_ready, 1'b0);
    tick();
    in_valid    = 1'b0;
    flush_valid = 1'b0;
    #1;
    chk("pf_empty", warp_empty, 4'hF);
    chk("pf_ov", out_valid, 1'b0);

    // reset mid-stream
    push(2'd0, 64'h90);
    tick();
    push(2'd1, 64'h91);
    tick();
    push(2'd3, 64'h93);
    tick();
    in_valid = 1'b0;
    #1;
    chk("mr_pre", warp_empty, 4'b0100);
    reset = 1'b1;
    #1;
    chk("mr_ov_in", out_valid, 1'b0);
    chk("mr_emp_in", warp_empty, 4'hF);
    chk("mr_rdy_in", in_ready, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    chk("mr_ov", out_valid, 1'b0);
    chk("mr_empty", warp_empty, 4'hF);
    chk("mr_full", warp_full, 4'h0);
    out_ready = 1'b1;
    push(2'd3, 64'hA0);
    tick();
    in_valid = 1'b0;
    #1;
    exp_out("mr_post", 2'd3, 64'hA0);
    tick();
    chk("mr_end", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
